rtc_read_sequencer: RTL and testbench

Upstream sequencer for the RTC read-control generator (`Signal_Control_Lectura`). A single `start` pulse triggers a full time snapshot. The block then:
- steps through the six RTC time registers,
- holds `enable_leer` high so the generator produces one 43-cycle read transaction per register,
- presents each register address on the address bus,
- captures each returned byte from the data bus.

All six bytes are published to the display/control logic together, with a one-cycle `done` pulse and a BCD sanity flag.

---
 rtl/rtc_pkg.sv | 26 ++
 rtl/rtc_bcd_check.sv | 9 +
 rtl/rtc_read_sequencer.sv | 130 +++++++++++++
 tb/tb_rtc_read_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: sequencer states, register map and generator
// counter landmarks, common to the read and write sequencers.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rtc_state_t;

  typedef logic [2:0] reg_idx_t;

  localparam int SNAP_REGS = 6;

  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;
  localparam logic [7:0] ADDR_DIA  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_ANIO = 8'h26;

  localparam logic [5:0] RTC_END_CNT     = 6'd42;
  localparam logic [5:0] RTC_CAPTURE_CNT = 6'd28;

endpackage

// File: rtl/rtc_bcd_check.sv
// Flags a byte whose upper or lower nibble is not a decimal digit.
module rtc_bcd_check (
  input  logic [7:0] val,
  output logic       nib_err
);

  assign nib_err = (val[7:4] > 4'd9) || (val[3:0] > 4'd9);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Walks the six RTC time registers through the read-control generator and
// publishes a complete snapshot with a done pulse and a BCD sanity flag.
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int         NUM_REGS    = 6,
  parameter logic [7:0] BASE_ADDR   = ADDR_SEG,
  parameter logic [5:0] CAPTURE_CNT = RTC_CAPTURE_CNT,
  parameter logic [5:0] END_CNT     = RTC_END_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] cont_lectura,
  input  logic [7:0] dato_in,
  output logic       enable_leer,
  output logic [7:0] dir_out,
  output logic       busy,
  output logic       done,
  output logic       bcd_err,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio
);

  rtc_state_t state, state_n;
  reg_idx_t   idx, idx_n;
  logic       cap, snap_ld;
  logic [7:0] shadow [SNAP_REGS];
  logic [SNAP_REGS-1:0] err_vec;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cap     = 1'b0;
    snap_ld = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_n   = '0;
          // A non-zero count means the generator froze mid-transaction.
          state_n = (cont_lectura == 6'd0) ? ST_RUN : ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (cont_lectura == END_CNT) begin
          state_n = ST_RUN;
          idx_n   = '0;
        end
      end
      ST_RUN: begin
        cap = (cont_lectura == CAPTURE_CNT);
        if (cont_lectura == END_CNT) begin
          if (idx == reg_idx_t'(NUM_REGS - 1)) begin
            state_n = ST_DONE;
            snap_ld = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they switch on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      enable_leer <= 1'b0;
      dir_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      enable_leer <= (state_n == ST_SYNC) || (state_n == ST_RUN);
      dir_out     <= (state_n == ST_RUN) ? (BASE_ADDR + {5'd0, idx_n}) : 8'd0;
      busy        <= (state_n != ST_IDLE);
      done        <= (state_n == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SNAP_REGS; i++) shadow[i] <= '0;
    end else if (cap) begin
      shadow[idx] <= dato_in;
    end
  end

  genvar g;
  generate
    for (g = 0; g < SNAP_REGS; g++) begin : g_bcd
      rtc_bcd_check u_chk (
        .val     (shadow[g]),
        .nib_err (err_vec[g])
      );
    end
  endgenerate

  // The last byte is captured well before END_CNT, so the shadow set is
  // complete when the snapshot loads and nothing partial is ever exposed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg     <= '0;
      min     <= '0;
      hora    <= '0;
      dia     <= '0;
      mes     <= '0;
      anio    <= '0;
      bcd_err <= 1'b0;
    end else if (snap_ld) begin
      seg     <= shadow[0];
      min     <= shadow[1];
      hora    <= shadow[2];
      dia     <= shadow[3];
      mes     <= shadow[4];
      anio    <= shadow[5];
      bcd_err <= |err_vec;
    end
  end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Scoreboard bench for rtc_read_sequencer with a read-generator model and an
// RTC register model driving the data bus.
module tb_rtc_read_sequencer;

  localparam int TLEN  = 43;
  localparam int NREGS = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] gen_cnt = 6'd0;
  logic [7:0] dato_in;
  logic       enable_leer, busy, done, bcd_err;
  logic [7:0] dir_out, seg, min, hora, dia, mes, anio;

  rtc_read_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont_lectura (gen_cnt),
    .dato_in      (dato_in),
    .enable_leer  (enable_leer),
    .dir_out      (dir_out),
    .busy         (busy),
    .done         (done),
    .bcd_err      (bcd_err),
    .seg          (seg),
    .min          (min),
    .hora         (hora),
    .dia          (dia),
    .mes          (mes),
    .anio         (anio)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-control generator: counts 0..42 while enabled, freezes otherwise.
  always @(posedge clk)
    if (enable_leer) gen_cnt <= (gen_cnt == 6'd42) ? 6'd0 : gen_cnt + 6'd1;

  // RTC register file answering on addresses 0x21..0x26.
  logic [7:0] rtc_mem [NREGS];
  always_comb begin
    dato_in = 8'hEE;
    if (dir_out >= 8'h21 && dir_out <= 8'h26) dato_in = rtc_mem[int'(dir_out) - 33];
  end

  typedef struct {
    logic [47:0] bytes;
    bit          err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [47:0] pub = '0;
  bit          pub_err = 1'b0;
  wire  [47:0] snap = {seg, min, hora, dia, mes, anio};

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit any_bad_bcd(input logic [47:0] b);
    for (int i = 0; i < NREGS; i++) begin
      int v = int'(b[8*i +: 8]);
      if (v / 16 > 9 || v % 16 > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected done edge: partial-transaction flush (if any) plus six full transactions.
  task automatic push_exp(input int e0, input int c0);
    exp_t e;
    e.bytes = {rtc_mem[0], rtc_mem[1], rtc_mem[2], rtc_mem[3], rtc_mem[4], rtc_mem[5]};
    e.err   = any_bad_bcd(e.bytes);
    e.due   = e0 + ((c0 == 0) ? 0 : (TLEN - c0)) + TLEN * NREGS;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      pub     = '0;
      pub_err = 1'b0;
    end else if (done) begin
      chk(enable_leer == 1'b0, "enable_in_done", 64'(enable_leer), 64'd0);
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_done", 64'd1, 64'd0);
        pub     = snap;
        pub_err = bcd_err;
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(cyc == e.due, "done_time", 64'(cyc), 64'(e.due));
        chk(snap == e.bytes, "snapshot", 64'(snap), 64'(e.bytes));
        chk(bcd_err == e.err, "bcd_err", 64'(bcd_err), 64'(e.err));
        pub     = e.bytes;
        pub_err = e.err;
      end
    end else begin
      if (snap != pub) chk(1'b0, "snapshot_hold", 64'(snap), 64'(pub));
      if (bcd_err != pub_err) chk(1'b0, "bcd_err_hold", 64'(bcd_err), 64'(pub_err));
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk(1'b0, "done_missing", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  // Issues a one-cycle start from a negedge; e0 is the edge that samples it.
  task automatic start_pulse(input bit accept, output int e0, output int c0);
    c0 = int'(gen_cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    if (accept) push_exp(e0, c0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      chk(1'b0, "wait_idle_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic fill_bcd();
    for (int i = 0; i < NREGS; i++)
      rtc_mem[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, c0, n;
    for (int i = 0; i < NREGS; i++) rtc_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk(enable_leer == 1'b0, "rst_enable", 64'(enable_leer), 64'd0);
    chk(dir_out == 8'h00, "rst_dir", 64'(dir_out), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(done == 1'b0, "rst_done", 64'(done), 64'd0);
    chk(snap == 48'd0 && bcd_err == 1'b0, "rst_snapshot", 64'(snap), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Normal read with address walk
    rtc_mem[0] = 8'h45; rtc_mem[1] = 8'h30; rtc_mem[2] = 8'h12;
    rtc_mem[3] = 8'h07; rtc_mem[4] = 8'h04; rtc_mem[5] = 8'h16;
    start_pulse(1'b1, e0, c0);
    chk(enable_leer == 1'b1, "enable_on_start", 64'(enable_leer), 64'd1);
    chk(busy == 1'b1, "busy_on_start", 64'(busy), 64'd1);
    chk(dir_out == 8'h21, "dir_first", 64'(dir_out), 64'h21);
    for (int i = 1; i < NREGS; i++) begin
      wait_cyc(e0 + TLEN * i + 5);
      chk(dir_out == 8'(8'h21 + i), "dir_step", 64'(dir_out), 64'(8'h21 + i));
    end
    wait_idle();
    chk(enable_leer == 1'b0 && busy == 1'b0, "idle_after_done", 64'({enable_leer, busy}), 64'd0);

    // Non-BCD minutes byte
    rtc_mem[1] = 8'h3A;
    start_pulse(1'b1, e0, c0);
    wait_idle();

    // Start while busy must be ignored
    fill_bcd();
    start_pulse(1'b1, e0, c0);
    wait_cyc(e0 + TLEN * 2 + 10);
    start_pulse(1'b0, n, c0);
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset mid-run at idx 3, count 17, then recovery through SYNC
    fill_bcd();
    start_pulse(1'b1, e0, c0);
    wait_cyc(e0 + TLEN * 3 + 17);
    chk(gen_cnt == 6'd17, "gen_at_reset", 64'(gen_cnt), 64'd17);
    rst = 1'b0;
    #1;
    chk({enable_leer, busy, done, bcd_err} == 4'b0, "rst_mid_ctrl", 64'({enable_leer, busy, done, bcd_err}), 64'd0);
    chk(dir_out == 8'h00 && snap == 48'd0, "rst_mid_data", 64'(snap), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk(gen_cnt == 6'd17, "gen_frozen", 64'(gen_cnt), 64'd17);
    rst = 1'b1;
    @(negedge clk);
    fill_bcd();
    start_pulse(1'b1, e0, c0);
    wait_cyc(e0 + 5);
    chk(enable_leer && busy && dir_out == 8'h00, "sync_phase", 64'({enable_leer, busy, dir_out}), 64'h300);
    wait_cyc(e0 + 27);
    chk(dir_out == 8'h21, "run_after_sync", 64'(dir_out), 64'h21);
    wait_idle();

    // Back-to-back: start during done is dropped, next cycle is accepted
    fill_bcd();
    start_pulse(1'b1, e0, c0);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(done == 1'b1, "b2b_first_done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    fill_bcd();
    c0 = int'(gen_cnt);
    chk(c0 == 0, "b2b_cont_zero", 64'(c0), 64'd0);
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    push_exp(e0, c0);
    wait_idle();

    // Random data, including non-BCD bytes, with random gaps
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREGS; i++)
        rtc_mem[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_pulse(1'b1, e0, c0);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
